// File: rtl/mmio_timer.sv
// Memory-mapped 64-bit prescaled timer with compare, sticky match flag and level IRQ.
// Same-cycle combinational read data; writes land at the clock edge with byte-lane masking.
module mmio_timer #(
  parameter int unsigned DW      = 32,
  parameter int unsigned PRESC_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    mask,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          irq_o
);

  typedef enum logic [2:0] {
    REG_MTIME_LO = 3'd0,
    REG_MTIME_HI = 3'd1,
    REG_CMP_LO   = 3'd2,
    REG_CMP_HI   = 3'd3,
    REG_CTRL     = 3'd4,
    REG_PRESC    = 3'd5,
    REG_STATUS   = 3'd6,
    REG_RSVD     = 3'd7
  } reg_idx_e;

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic [31:0]        hi_shadow;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic               en;
  logic               irq_en;
  logic               pending;

  reg_idx_e    idx;
  logic [31:0] wd;
  logic        wr_en;
  logic        mtime_wr;
  logic        presc_wr;
  logic        snap;
  logic        tick;
  logic        match;
  logic        w1c;
  logic [31:0] presc_merged;
  logic [31:0] rd_word;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  lanes);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign idx      = reg_idx_e'(addr_i[4:2]);
  assign wd       = wdata_i[31:0];
  // A zero mask is a full no-op, including the prescaler restart side effects.
  assign wr_en    = !cs && we && (mask != '0);
  assign mtime_wr = wr_en && ((idx == REG_MTIME_LO) || (idx == REG_MTIME_HI));
  assign presc_wr = wr_en && (idx == REG_PRESC);
  assign snap     = !cs && re && !we && (idx == REG_MTIME_LO);
  assign tick     = en && (presc_cnt == presc);
  assign match    = en && (mtime >= mtimecmp);
  assign w1c      = wr_en && (idx == REG_STATUS) && mask[0] && wd[0];

  assign presc_merged = merge_lanes(32'(presc), wd, mask);

  logic unused_bits;
  assign unused_bits = ^{addr_i[DW-1:5], addr_i[1:0], presc_merged[31:PRESC_W]};

  // A software write to mtime suppresses that cycle's increment and restarts the prescaler.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime     <= '0;
      presc_cnt <= '0;
    end else if (mtime_wr) begin
      if (idx == REG_MTIME_LO) mtime[31:0]  <= merge_lanes(mtime[31:0], wd, mask);
      else                     mtime[63:32] <= merge_lanes(mtime[63:32], wd, mask);
      presc_cnt <= '0;
    end else begin
      if (tick) mtime <= mtime + 64'd1;
      if (presc_wr || tick) presc_cnt <= '0;
      else if (en)          presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtimecmp <= '1;
      presc    <= '0;
      en       <= 1'b0;
      irq_en   <= 1'b0;
    end else if (wr_en) begin
      case (idx)
        REG_CMP_LO: mtimecmp[31:0]  <= merge_lanes(mtimecmp[31:0], wd, mask);
        REG_CMP_HI: mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], wd, mask);
        REG_CTRL: begin
          if (mask[0]) begin
            en     <= wd[0];
            irq_en <= wd[1];
          end
        end
        REG_PRESC:  presc <= presc_merged[PRESC_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     hi_shadow <= '0;
    else if (snap) hi_shadow <= mtime[63:32];
  end

  // Set has priority over W1C so a live match can never be lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)      pending <= 1'b0;
    else if (match) pending <= 1'b1;
    else if (w1c)   pending <= 1'b0;
  end

  assign irq_o = pending & irq_en;

  always_comb begin
    rd_word = '0;
    if (!cs) begin
      case (idx)
        REG_MTIME_LO: rd_word = mtime[31:0];
        REG_MTIME_HI: rd_word = hi_shadow;
        REG_CMP_LO:   rd_word = mtimecmp[31:0];
        REG_CMP_HI:   rd_word = mtimecmp[63:32];
        REG_CTRL:     rd_word = {30'd0, irq_en, en};
        REG_PRESC:    rd_word = 32'(presc);
        REG_STATUS:   rd_word = {31'd0, pending};
        default:      rd_word = '0;
      endcase
    end
  end

  assign rdata_o = DW'(rd_word);

endmodule

// File: tb/tb_mmio_timer.sv
// Testbench for mmio_timer: directed corner sequences, a vector table and randomized traffic
// against a reference model that derives mtime from elapsed enabled cycles.
module tb_mmio_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  mmio_timer #(.DW(32), .PRESC_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .cs(cs), .we(we), .re(re), .mask(mask),
    .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .irq_o(irq)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  // Reference model: mtime = base + elapsed_enabled_cycles / (PRESC+1)
  logic [63:0] m_base, m_elapsed, m_cmp;
  logic [31:0] m_shadow;
  logic [15:0] m_presc;
  bit          m_en, m_irq_en, m_pending;

  function automatic logic [63:0] m_mtime();
    return m_base + m_elapsed / (64'(m_presc) + 64'd1);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] idx);
    logic [63:0] t;
    t = m_mtime();
    case (idx)
      3'd0: return t[31:0];
      3'd1: return m_shadow;
      3'd2: return m_cmp[31:0];
      3'd3: return m_cmp[63:32];
      3'd4: return {30'd0, m_irq_en, m_en};
      3'd5: return {16'd0, m_presc};
      3'd6: return {31'd0, m_pending};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_reset();
    m_base = '0; m_elapsed = '0; m_cmp = '1; m_shadow = '0;
    m_presc = '0; m_en = 0; m_irq_en = 0; m_pending = 0;
  endtask

  task automatic m_step(input bit c, input bit w, input bit r, input logic [2:0] idx,
                        input logic [3:0] m, input logic [31:0] d);
    logic [63:0] cur, nat_el;
    logic [31:0] t32;
    bit wr, hit, clr;
    cur    = m_mtime();
    nat_el = m_elapsed + (m_en ? 64'd1 : 64'd0);
    hit    = m_en && (cur >= m_cmp);
    wr     = !c && w && (m != 4'd0);
    clr    = 0;
    if (!c && r && !w && idx == 3'd0) m_shadow = cur[63:32];
    m_elapsed = nat_el;
    if (wr) begin
      case (idx)
        3'd0: begin m_base = {cur[63:32], lanes(cur[31:0], d, m)}; m_elapsed = '0; end
        3'd1: begin m_base = {lanes(cur[63:32], d, m), cur[31:0]}; m_elapsed = '0; end
        3'd2: m_cmp[31:0]  = lanes(m_cmp[31:0], d, m);
        3'd3: m_cmp[63:32] = lanes(m_cmp[63:32], d, m);
        3'd4: if (m[0]) begin m_en = d[0]; m_irq_en = d[1]; end
        3'd5: begin
          m_base    = m_base + nat_el / (64'(m_presc) + 64'd1);
          m_elapsed = '0;
          t32       = lanes({16'd0, m_presc}, d, m);
          m_presc   = t32[15:0];
        end
        3'd6: clr = m[0] && d[0];
        default: ;
      endcase
    end
    m_pending = hit || (m_pending && !clr);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at posedge+1; drives one bus cycle, checks mid-cycle, advances one edge.
  task automatic op(input bit c, input bit w, input bit r, input logic [2:0] idx,
                    input logic [3:0] m, input logic [31:0] d,
                    input bit has_exp, input logic [31:0] exp, input string name);
    cs = c; we = w; re = r; mask = m; wdata = d;
    addr = {27'($urandom), idx, 2'($urandom)};
    #2;
    chk("rdata_vs_model", rdata, c ? 32'd0 : m_read(idx));
    chk("irq_vs_model", {31'd0, irq}, {31'd0, m_pending & m_irq_en});
    if (has_exp) chk(name, rdata, exp);
    m_step(c, w, r, idx, m, d);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b0; re = 1'b0; mask = '0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] m);
    op(0, 1, 0, idx, m, d, 0, 32'd0, "");
  endtask

  task automatic rd(input logic [2:0] idx, input string name, input logic [31:0] exp);
    op(0, 0, 1, idx, 4'd0, 32'd0, 1, exp, name);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1, 0, 0, 3'd0, 4'd0, 32'd0, 0, 32'd0, "");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          c, w, r;
    logic [2:0]  idx;
    logic [3:0]  m;
    logic [31:0] d;
    bit          has;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Asynchronous reset mid-count
    wr(3'd4, 32'h1, 4'h1);
    wr(3'd0, 32'h1230, 4'hF);
    idle(4);
    rd(3'd0, "count_before_reset", 32'h1234);
    wr(3'd2, 32'h0, 4'hF);
    wr(3'd3, 32'h0, 4'hF);
    wr(3'd4, 32'h3, 4'h1);
    chk("irq_before_reset", {31'd0, irq}, 32'd1);
    cs = 1'b0; re = 1'b0; we = 1'b0; addr = {27'd0, 3'd3, 2'd0};
    #2;
    rst = 1'b1;
    #1;
    chk("reset_cmp_hi", rdata, 32'hFFFF_FFFF);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    addr = {27'd0, 3'd0, 2'd0};
    #1;
    chk("reset_mtime_lo", rdata, 32'd0);
    cs = 1'b1;
    #1;
    chk("reset_rdata_deselected", rdata, 32'd0);
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    rd(3'd0, "no_count_while_disabled", 32'd0);

    // Prescaler
    do_reset();
    wr(3'd5, 32'd3, 4'hF);
    wr(3'd4, 32'd1, 4'h1);
    idle(40);
    rd(3'd0, "presc3_40_cycles", 32'd10);
    wr(3'd5, 32'd0, 4'hF);
    idle(5);
    rd(3'd0, "presc0_5_cycles", 32'd15);

    // Wrap of the low word and tear-free snapshot
    do_reset();
    wr(3'd1, 32'h0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd4, 32'd1, 4'h1);
    rd(3'd0, "wrap_lo", 32'hFFFF_FFFF);
    rd(3'd1, "wrap_hi_shadow", 32'h0);
    rd(3'd0, "post_wrap_lo", 32'h1);
    rd(3'd1, "post_wrap_hi", 32'h1);

    // Full 64-bit wrap
    wr(3'd4, 32'd0, 4'h1);
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    wr(3'd4, 32'd1, 4'h1);
    rd(3'd0, "wrap64_lo", 32'hFFFF_FFFF);
    rd(3'd1, "wrap64_hi", 32'hFFFF_FFFF);
    rd(3'd0, "wrap64_after_lo", 32'h1);
    rd(3'd1, "wrap64_after_hi", 32'h0);

    // Match and interrupt
    do_reset();
    wr(3'd2, 32'd20, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd4, 32'd3, 4'h1);
    idle(20);
    chk("irq_before_match", {31'd0, irq}, 32'd0);
    rd(3'd0, "mtime_at_cmp", 32'd20);
    chk("irq_after_match", {31'd0, irq}, 32'd1);
    rd(3'd6, "pending_set", 32'd1);
    wr(3'd6, 32'd1, 4'h1);
    chk("w1c_during_match", {31'd0, irq}, 32'd1);
    idle(1);
    chk("pending_still_set", {31'd0, irq}, 32'd1);
    wr(3'd2, 32'd1000, 4'hF);
    chk("cmp_write_uses_old", {31'd0, irq}, 32'd1);
    wr(3'd6, 32'd1, 4'h1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    rd(3'd6, "pending_cleared", 32'd0);

    // Write/tick collision and W1C/match collision
    wr(3'd0, 32'h50, 4'hF);
    rd(3'd0, "collision_write_wins", 32'h50);
    rd(3'd0, "collision_then_count", 32'h51);
    wr(3'd2, 32'h10, 4'hF);
    chk("no_match_on_cmp_edge", {31'd0, irq}, 32'd0);
    wr(3'd6, 32'd1, 4'h1);
    chk("w1c_vs_match_set_wins", {31'd0, irq}, 32'd1);

    // Register access vectors from reset
    do_reset();
    tbl[0]  = '{0, 1, 0, 3'd2, 4'h5, 32'hAABB_CCDD, 0, 32'h0};
    tbl[1]  = '{0, 0, 1, 3'd2, 4'h0, 32'h0,         1, 32'hFFBB_FFDD};
    tbl[2]  = '{0, 0, 1, 3'd3, 4'h0, 32'h0,         1, 32'hFFFF_FFFF};
    tbl[3]  = '{0, 1, 0, 3'd2, 4'h0, 32'h1234_5678, 0, 32'h0};
    tbl[4]  = '{0, 0, 1, 3'd2, 4'h0, 32'h0,         1, 32'hFFBB_FFDD};
    tbl[5]  = '{0, 1, 0, 3'd7, 4'hF, 32'h1234_5678, 0, 32'h0};
    tbl[6]  = '{0, 0, 1, 3'd7, 4'h0, 32'h0,         1, 32'h0};
    tbl[7]  = '{0, 0, 1, 3'd2, 4'h0, 32'h0,         1, 32'hFFBB_FFDD};
    tbl[8]  = '{0, 1, 0, 3'd4, 4'hF, 32'hFFFF_FFFE, 0, 32'h0};
    tbl[9]  = '{0, 0, 1, 3'd4, 4'h0, 32'h0,         1, 32'h2};
    tbl[10] = '{0, 1, 0, 3'd5, 4'hF, 32'h0001_2345, 0, 32'h0};
    tbl[11] = '{0, 0, 1, 3'd5, 4'h0, 32'h0,         1, 32'h2345};
    tbl[12] = '{0, 1, 0, 3'd5, 4'h2, 32'h0000_00AB, 0, 32'h0};
    tbl[13] = '{0, 0, 1, 3'd5, 4'h0, 32'h0,         1, 32'h45};
    tbl[14] = '{1, 0, 1, 3'd2, 4'h0, 32'h0,         1, 32'h0};
    tbl[15] = '{0, 0, 1, 3'd6, 4'h0, 32'h0,         1, 32'h0};
    tbl[16] = '{0, 0, 1, 3'd0, 4'h0, 32'h0,         1, 32'h0};
    tbl[17] = '{0, 1, 0, 3'd4, 4'hF, 32'h0,         0, 32'h0};
    for (int i = 0; i < 18; i++)
      op(tbl[i].c, tbl[i].w, tbl[i].r, tbl[i].idx, tbl[i].m, tbl[i].d,
         tbl[i].has, tbl[i].exp, $sformatf("vec%0d", i));

    // Randomized traffic against the model
    do_reset();
    wr(3'd2, 32'd60, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd4, 32'd3, 4'h1);
    for (int n = 0; n < 600; n++) begin
      int unsigned sel;
      logic [2:0]  idx;
      logic [31:0] d;
      sel = $urandom_range(0, 9);
      idx = 3'($urandom);
      case (idx)
        3'd0: d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                             : 32'($urandom_range(0, 100));
        3'd1: d = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom);
        3'd2: d = 32'($urandom_range(0, 300));
        3'd3: d = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'd0;
        3'd4: d = 32'($urandom_range(0, 3));
        3'd5: d = 32'($urandom_range(0, 3));
        default: d = 32'($urandom);
      endcase
      if (sel <= 3)
        op(0, 0, 1'($urandom), idx, 4'($urandom), 32'($urandom), 0, 32'd0, "");
      else if (sel <= 6)
        op(0, 1, 1'($urandom), idx, 4'($urandom), d, 0, 32'd0, "");
      else if (sel == 7)
        op(1, 1'($urandom), 1'($urandom), idx, 4'($urandom), d, 0, 32'd0, "");
      else
        idle(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped 64-bit timer responder on the core's data-memory bus, selected alongside `data_mem`. It answers the LSU's chip-select, write-enable, byte-mask, address and write-data transfers with same-cycle read data, exactly as `data_mem` does. It runs a prescaled 64-bit up-counter (`mtime`) against a 64-bit compare register (`mtimecmp`), latches a sticky match flag, and drives a level interrupt request toward the core.

## Interface
- `DW`, 32, bus data width (must be 32)
- `PRESC_W`, 16, prescaler width
- `clk_i` input 1, core clock
- `rst_i` input 1, reset, asynchronous, active-high
- `cs` input 1, chip select, active-low (0 = selected)
- `we` input 1, write strobe, valid when `cs`=0
- `re` input 1, load strobe, valid when `cs`=0; used only for the snapshot side effect
- `mask` input 4, byte-lane enables for writes; bit n enables `wdata_i[8n+7:8n]`
- `addr_i` input DW, byte address; only `addr_i[4:2]` is decoded, `[1:0]` is ignored
- `wdata_i` input DW, write data, already lane-aligned by the LSU
- `rdata_o` output DW, read data, combinational
- `irq_o` output 1, timer interrupt request, level

## Operation
- Register map, by word index `addr_i[4:2]`:
  - 0 `MTIME_LO`
  - 1 `MTIME_HI`
  - 2 `CMP_LO`
  - 3 `CMP_HI`
  - 4 `CTRL`: bit0 `en`, bit1 `irq_en`, other bits read 0
  - 5 `PRESC`: `[PRESC_W-1:0]`
  - 6 `STATUS`: bit0 `pending`, write-1-to-clear
  - 7 reserved: reads 0, writes ignored
- Write: takes effect at the rising edge when `cs`=0 and `we`=1. Only lanes with `mask` bit set are updated. `mask`=0 is a no-op.
- Read: `rdata_o` is driven combinationally from the decoded register when `cs`=0, otherwise 0.
  - `MTIME_HI` returns `hi_shadow`, not the live upper word.
- Snapshot: at the edge where `cs`=0, `re`=1, `we`=0 and index=0, `hi_shadow <= mtime[63:32]`. A LO-then-HI read pair is therefore tear-free.
- Prescaler: `presc_cnt` counts 0..`PRESC` while `en`=1.
  - At the edge where `presc_cnt`==`PRESC`: `presc_cnt <= 0` and `mtime <= mtime+1`.
  - `PRESC`=0 gives one increment per cycle.
  - `mtime` wraps from 2^64-1 to 0 with no flag.
- `en`=0: `presc_cnt` and `mtime` hold. Software writes still apply.
- Match: at every edge with `en`=1 and unsigned `mtime >= mtimecmp` (current register values), `pending <= 1`. `pending` is sticky.
- `irq_o = pending & irq_en`, purely from registers, so it is glitch-free.
- Simultaneous events:
  - Write to `MTIME_LO`/`MTIME_HI` coincides with a tick: the write wins. The selected lanes load `wdata_i`, all other `mtime` bits hold (no increment that cycle), and `presc_cnt <= 0`.
  - Write to `PRESC`: `presc_cnt <= 0` that edge.
  - W1C of `pending` coincides with a match condition: set wins, `pending` stays 1.
  - Write to `CMP_*`: the compare at that edge uses the old value; the new value is used from the next edge.
- Snapshot read and a write to `MTIME_HI` in the same cycle cannot occur, because `re` and `we` are mutually exclusive. If both are asserted, the write takes priority and no snapshot is taken.

## Timing
- Reset (async, immediate):
  - `mtime`=0, `hi_shadow`=0, `presc_cnt`=0, `PRESC`=0
  - `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF
  - `CTRL`=0, `pending`=0, `irq_o`=0
  - `rdata_o`=0 while `cs`=1
- Reset asserted mid-count clears all state within the same cycle. The counter restarts from 0 only after software sets `en`.
- Read latency is 0 cycles: combinational, sampled by the LSU in the same M-stage cycle. Write latency is 1 edge.
- With `en`=1 and `PRESC`=P, `mtime` advances every P+1 cycles.
- `pending` rises at the first edge where `mtime >= mtimecmp`, i.e. one cycle after `mtime` reaches the compare value. `irq_o` follows in the same cycle as `pending`.
- Clearing `pending` while `mtime >= mtimecmp` and `en`=1 re-sets it at the next edge. Software must raise `mtimecmp` before clearing.

## Test plan
- Reset: assert `rst_i` mid-count with `mtime`=0x1234 → `mtime`=0, `irq_o`=0, and a read of `CMP_HI` returns 0xFFFFFFFF without any clock edge.
- Prescale/count: `PRESC`=3, `en`=1, run 40 cycles → `MTIME_LO` reads 10. `PRESC`=0, run 5 cycles → +5.
- Byte masks: write 0xAABBCCDD to `CMP_LO` with `mask`=4'b0101 → `CMP_LO` reads 0xFFBBFFDD. A write to index 7 → reads 0, nothing else changes.
- Wrap and snapshot: `mtime` = 0x00000000_FFFFFFFF, `en`=1, `PRESC`=0.
  - Read LO at the edge where it wraps → LO = 0xFFFFFFFF, then HI = 0 (shadow), not 1.
  - Next LO/HI pair → LO=1, HI=1.
- Match/IRQ: `CMP`=20, `PRESC`=0, `irq_en`=1, `en`=1 from `mtime`=0 → `pending`/`irq_o` rise on the edge after `mtime`=20.
  - W1C with `CMP` unchanged → re-sets the next cycle.
  - Set `CMP`=1000, then W1C → `irq_o`=0.
- Collision: with `PRESC`=0, write `MTIME_LO`=0x50 with `mask`=4'hF in a tick cycle → reads 0x50 the next cycle, then 0x51. W1C coincident with a match → `pending` stays 1.
